threshold_sweep_ctrl: RTL and testbench

Digital controller for the programmable threshold voltage sensor. It drives the 3-bit threshold select code into the one-hot threshold decoder and consumes the analog comparator output. It steps the threshold, waits for the analog node to settle, and majority-votes the comparator. It reports either a single-threshold result or a full sweep result (level 0–8 plus an 8-bit thermometer word) on the dedicated outputs.

---
 rtl/threshold_sweep_ctrl.sv | 166 ++++++++++++++++
 tb/tb_threshold_sweep_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : threshold_sweep_ctrl
// Brief    : Threshold step/settle/majority-vote controller for the voltage
//            sensor; optional comparator synchronizer via SENSOR_CMP_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module threshold_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned SAMPLES       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode,
   input  logic [2:0] code_in,
   input  logic       cmp_in,
   output logic [2:0] sel_code,
   output logic       busy,
   output logic       done,
   output logic [3:0] level,
   output logic [7:0] therm
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_SAMPLE = 3'd2,
      S_EVAL   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);
   localparam logic [4:0] SAMPLES_W   = 5'(SAMPLES);

   state_t     state_q, state_d;
   logic       mode_q,  mode_d;
   logic [2:0] sel_q,   sel_d;
   logic [7:0] cnt_q,   cnt_d;
   logic [3:0] ones_q,  ones_d;
   logic [3:0] level_q, level_d;
   logic [7:0] therm_q, therm_d;
   logic       cmp_s;
   logic       vote;

`ifdef SENSOR_CMP_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], cmp_in};
      end
   end

   assign cmp_s = sync_q[1];
`else
   assign cmp_s = cmp_in;
`endif

   // Strict majority: 2*ones > SAMPLES, so a tie votes 0.
   assign vote = ({ones_q, 1'b0} > SAMPLES_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         sel_q   <= 3'd0;
         cnt_q   <= 8'd0;
         ones_q  <= 4'd0;
         level_q <= 4'd0;
         therm_q <= 8'h00;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         ones_q  <= ones_d;
         level_q <= level_d;
         therm_q <= therm_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      ones_d  = ones_q;
      level_d = level_q;
      therm_d = therm_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               sel_d   = mode ? 3'd0 : code_in;
               therm_d = 8'h00;
               ones_d  = 4'd0;
               cnt_d   = 8'd0;
               state_d = S_SETTLE;
            end
         end

         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_SAMPLE: begin
            if (cmp_s && (ones_q != 4'hF)) begin
               ones_d = ones_q + 4'd1;
            end
            if (cnt_q == SAMPLE_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_EVAL;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_EVAL: begin
            therm_d[sel_q] = vote;
            ones_d         = 4'd0;
            if (mode_q) begin
               if (vote && (sel_q != 3'd7)) begin
                  sel_d   = sel_q + 3'd1;
                  state_d = S_SETTLE;
               end else if (vote) begin
                  // Every code passed; report 8 rather than wrapping the code.
                  level_d = 4'd8;
                  state_d = S_DONE;
               end else begin
                  level_d = {1'b0, sel_q};
                  state_d = S_DONE;
               end
            end else begin
               level_d = {3'b000, vote};
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign sel_code = sel_q;
   assign busy     = (state_q == S_SETTLE) || (state_q == S_SAMPLE) || (state_q == S_EVAL);
   assign done     = (state_q == S_DONE);
   assign level    = level_q;
   assign therm    = therm_q;

endmodule
`default_nettype wire

// File: tb/tb_threshold_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_threshold_sweep_ctrl
// Brief    : Directed bench for threshold_sweep_ctrl (SETTLE=4; SAMPLES=3,4,1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_threshold_sweep_ctrl;

`ifdef SENSOR_CMP_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      start_v;
   logic [2:0]      mode_v;
   logic [2:0][2:0] code_v;
   logic [2:0]      cmp_man;
   logic [2:0]      cmp_v;
   logic [2:0][2:0] sel_v;
   logic [2:0]      busy_v;
   logic [2:0]      done_v;
   logic [2:0][3:0] level_v;
   logic [2:0][7:0] therm_v;
   logic            sel_en;
   logic [3:0]      thr;

   int vecs = 0;
   int errs = 0;

   int         r_first, r_pulses;
   logic       r_busy1, r_busyd, r_busyprev;
   logic [2:0] r_sel1, r_seld;
   logic [3:0] r_level;
   logic [7:0] r_therm;

   // Comparator model: passes for codes below thr, or driven by hand.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cmp_v[i] = sel_en ? ({1'b0, sel_v[i]} < thr) : cmp_man[i];
      end
   end

   threshold_sweep_ctrl #(.SETTLE_CYCLES(4), .SAMPLES(3)) u_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]),
      .code_in(code_v[0]), .cmp_in(cmp_v[0]), .sel_code(sel_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .level(level_v[0]), .therm(therm_v[0]));

   threshold_sweep_ctrl #(.SETTLE_CYCLES(4), .SAMPLES(4)) u_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]),
      .code_in(code_v[1]), .cmp_in(cmp_v[1]), .sel_code(sel_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .level(level_v[1]), .therm(therm_v[1]));

   threshold_sweep_ctrl #(.SETTLE_CYCLES(4), .SAMPLES(1)) u_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode_v[2]),
      .code_in(code_v[2]), .cmp_in(cmp_v[2]), .sel_code(sel_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .level(level_v[2]), .therm(therm_v[2]));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns just after the accepting edge E; mode/code are then scrambled.
   task automatic start_run(input int idx, input logic m, input logic [2:0] c);
      @(negedge clk);
      start_v[idx] = 1'b1;
      mode_v[idx]  = m;
      code_v[idx]  = c;
      @(posedge clk);
      #1;
      start_v[idx] = 1'b0;
      mode_v[idx]  = ~m;
      code_v[idx]  = ~c;
   endtask

   // Observes cycles 1..limit after E at the falling edge. pmode 1 drives pat
   // bit i into sample i; pmode 2 raises cmp from cycle 4. p1/p2 pulse start.
   task automatic run(input int idx, input int limit, input int pmode,
                      input logic [15:0] pat, input int p1, input int p2);
      int   pi;
      logic prev;
      r_first  = 0;
      r_pulses = 0;
      r_busy1  = 1'bx;
      r_busyd  = 1'bx;
      r_busyprev = 1'bx;
      r_sel1   = 3'bxxx;
      r_seld   = 3'bxxx;
      r_level  = 4'bxxxx;
      r_therm  = 8'hxx;
      prev     = 1'bx;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (k == 1) begin
            r_busy1 = busy_v[idx];
            r_sel1  = sel_v[idx];
         end
         if (done_v[idx]) begin
            r_pulses++;
            if (r_first == 0) begin
               r_first    = k;
               r_busyd    = busy_v[idx];
               r_busyprev = prev;
               r_level    = level_v[idx];
               r_therm    = therm_v[idx];
               r_seld     = sel_v[idx];
            end
         end
         prev = busy_v[idx];
         start_v[idx] = (k == p1) || (k == p2);
         if (pmode == 1) begin
            pi = k + LAT - 5;
            cmp_man[idx] = (pi >= 0 && pi < 16) ? pat[pi] : 1'b0;
         end else if (pmode == 2) begin
            cmp_man[idx] = (k >= 4);
         end
      end
      start_v[idx] = 1'b0;
      cmp_man[idx] = 1'b0;
   endtask

   initial begin
      int found;
      rst     = 1'b1;
      start_v = '0;
      mode_v  = '0;
      code_v  = '0;
      cmp_man = '0;
      sel_en  = 1'b1;
      thr     = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel",   32'(sel_v[0]),   32'd0);
      chk("rst_busy",  32'(busy_v[0]),  32'd0);
      chk("rst_done",  32'(done_v[0]),  32'd0);
      chk("rst_level", 32'(level_v[0]), 32'd0);
      chk("rst_therm", 32'(therm_v[0]), 32'h00);
      @(negedge clk);
      rst = 1'b0;

      // Sweep: codes 0..4 pass, code 5 fails.
      thr = 4'd5;
      start_run(0, 1'b1, 3'd6);
      run(0, 53, 0, 16'h0, 0, 0);
      chk("sw5_busy1", 32'(r_busy1), 32'd1);
      chk("sw5_sel1",  32'(r_sel1),  32'd0);
      chk("sw5_doneat", 32'(r_first), 32'd49);
      chk("sw5_pulses", 32'(r_pulses), 32'd1);
      chk("sw5_level", 32'(r_level), 32'd5);
      chk("sw5_therm", 32'(r_therm), 32'h1F);
      chk("sw5_sel",   32'(r_seld),  32'd5);
      chk("sw5_busyd", 32'(r_busyd), 32'd0);
      chk("sw5_busyprev", 32'(r_busyprev), 32'd1);
      chk("sw5_hold_level", 32'(level_v[0]), 32'd5);

      // Sweep: every code passes, no wrap.
      thr = 4'd8;
      start_run(0, 1'b1, 3'd2);
      run(0, 69, 0, 16'h0, 0, 0);
      chk("sw8_doneat", 32'(r_first), 32'd65);
      chk("sw8_level", 32'(r_level), 32'd8);
      chk("sw8_therm", 32'(r_therm), 32'hFF);
      chk("sw8_sel",   32'(r_seld),  32'd7);
      chk("sw8_sel_idle", 32'(sel_v[0]), 32'd7);

      // Reset in the middle of a sweep at code 3.
      start_run(0, 1'b1, 3'd0);
      found = 0;
      for (int k = 0; k < 100 && found == 0; k++) begin
         @(negedge clk);
         if (sel_v[0] == 3'd3) found = 1;
      end
      chk("mid_reach_code3", 32'(found), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_sel",   32'(sel_v[0]),   32'd0);
      chk("mid_rst_busy",  32'(busy_v[0]),  32'd0);
      chk("mid_rst_done",  32'(done_v[0]),  32'd0);
      chk("mid_rst_level", 32'(level_v[0]), 32'd0);
      chk("mid_rst_therm", 32'(therm_v[0]), 32'h00);
      @(negedge clk);
      rst = 1'b0;
      thr = 4'd5;
      start_run(0, 1'b1, 3'd6);
      run(0, 53, 0, 16'h0, 0, 0);
      chk("post_rst_doneat", 32'(r_first), 32'd49);
      chk("post_rst_level", 32'(r_level), 32'd5);
      chk("post_rst_therm", 32'(r_therm), 32'h1F);

      // Single mode at code 3, comparator high then low.
      thr = 4'd8;
      start_run(0, 1'b0, 3'd3);
      run(0, 13, 0, 16'h0, 0, 0);
      chk("s3h_sel1",   32'(r_sel1),  32'd3);
      chk("s3h_doneat", 32'(r_first), 32'd9);
      chk("s3h_level",  32'(r_level), 32'd1);
      chk("s3h_therm",  32'(r_therm), 32'h08);
      chk("s3h_sel_idle", 32'(sel_v[0]), 32'd3);
      thr = 4'd0;
      start_run(0, 1'b0, 3'd3);
      run(0, 13, 0, 16'h0, 0, 0);
      chk("s3l_level", 32'(r_level), 32'd0);
      chk("s3l_therm", 32'(r_therm), 32'h00);

      // start pulsed while busy (cycle 3) and in the DONE cycle (cycle 9).
      thr = 4'd8;
      start_run(0, 1'b0, 3'd5);
      run(0, 30, 0, 16'h0, 3, 9);
      chk("ign_doneat", 32'(r_first),  32'd9);
      chk("ign_pulses", 32'(r_pulses), 32'd1);
      chk("ign_therm",  32'(r_therm),  32'h20);
      chk("ign_busy_after", 32'(busy_v[0]), 32'd0);

      // Majority vote patterns (hand-driven comparator).
      sel_en = 1'b0;
      start_run(0, 1'b0, 3'd1);
      run(0, 13, 1, 16'b101, 0, 0);
      chk("maj3_101", 32'(r_level), 32'd1);
      start_run(0, 1'b0, 3'd1);
      run(0, 13, 1, 16'b001, 0, 0);
      chk("maj3_100", 32'(r_level), 32'd0);
      start_run(1, 1'b0, 3'd2);
      run(1, 14, 1, 16'b0011, 0, 0);
      chk("maj4_doneat", 32'(r_first), 32'd10);
      chk("maj4_tie",   32'(r_level), 32'd0);
      start_run(1, 1'b0, 3'd2);
      run(1, 14, 1, 16'b0111, 0, 0);
      chk("maj4_1110", 32'(r_level), 32'd1);
      chk("maj4_therm", 32'(r_therm), 32'h04);
      start_run(2, 1'b0, 3'd6);
      run(2, 11, 1, 16'b1, 0, 0);
      chk("maj1_doneat", 32'(r_first), 32'd7);
      chk("maj1_one", 32'(r_level), 32'd1);

      // Comparator rises one cycle before SAMPLE.
      start_run(2, 1'b0, 3'd0);
      run(2, 11, 2, 16'h0, 0, 0);
      chk("late_edge_level", 32'(r_level), (LAT == 0) ? 32'd1 : 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
`default_nettype wire
